// File: rtl/store_write_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : store_write_ctrl_if
// Description : Store-request channel and data-memory write channel bundled
//               for store_write_ctrl. The slave modport is the controller's
//               view; the master modport is the pipeline/memory side.
// Revision    : 1.0 - initial release
// ============================================================================
interface store_write_ctrl_if;
  logic        st_valid;
  logic        st_ready;
  logic [2:0]  st_funct3;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        st_illegal;
  logic        st_misaligned;
  logic        busy;

  modport slave (
    input  st_valid, st_funct3, st_addr, st_data, mem_gnt,
    output st_ready, mem_req, mem_addr, mem_wdata, mem_be,
    output st_illegal, st_misaligned, busy
  );

  modport master (
    output st_valid, st_funct3, st_addr, st_data, mem_gnt,
    input  st_ready, mem_req, mem_addr, mem_wdata, mem_be,
    input  st_illegal, st_misaligned, busy
  );
endinterface
`default_nettype wire

// File: rtl/store_write_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : store_write_ctrl
// Description : Buffers SB/SH/SW stores in a DEPTH-entry in-order FIFO and
//               writes them to data memory as lane-aligned req/gnt beats.
//               Illegal funct3 is dropped with a st_illegal pulse.
//               Macro MISALIGN_SPLIT_EN: when defined, misaligned stores are
//               accepted and word-crossing ones are split into two beats;
//               when undefined they are dropped with a st_misaligned pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module store_write_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  store_write_ctrl_if.slave bus_if
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] C_PTR_ONE = AW'(1);
  localparam logic [2:0]  F3_SB     = 3'b000;
  localparam logic [2:0]  F3_SH     = 3'b001;
  localparam logic [2:0]  F3_SW     = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  entry_t        fifo_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  state_t        state_q;
  logic          req_q;
  logic [31:0]   addr_q, wdata_q;
  logic [3:0]    be_q;
  logic [31:0]   b1_addr_q, b1_wdata_q;
  logic [3:0]    b1_be_q;
  logic          split_q;
  logic          illegal_q, misaligned_q;

  logic          w_full, w_accept, w_bad_f3, w_push, w_pop, w_split;
  entry_t        w_head;
  logic [3:0]    w_sz;
  logic [31:0]   w_mdata;
  logic [7:0]    w_be64;
  logic [63:0]   w_d64;

  // Full means the FIFO alone is full; the entry held in the working
  // registers does not count, so a pop in the same cycle never frees a slot.
  assign w_full   = (count_q == C_FULL);
  assign w_accept = bus_if.st_valid & ~w_full;
  assign w_bad_f3 = !(bus_if.st_funct3 inside {F3_SB, F3_SH, F3_SW});
  assign w_pop    = (state_q == IDLE) && (count_q != '0);
  assign w_head   = fifo_q[rd_ptr_q];

`ifdef MISALIGN_SPLIT_EN
  assign w_push  = w_accept & ~w_bad_f3;
  assign w_split = |w_be64[7:4];
`else
  logic w_misaligned;
  assign w_misaligned = ((bus_if.st_funct3 == F3_SH) && bus_if.st_addr[0]) ||
                        ((bus_if.st_funct3 == F3_SW) && (bus_if.st_addr[1:0] != 2'b00));
  assign w_push  = w_accept & ~w_bad_f3 & ~w_misaligned;
  assign w_split = 1'b0;
`endif

  // Lane math for the FIFO head: a 64-bit window spanning this word and the next.
  always_comb begin
    w_sz    = 4'hF;
    w_mdata = w_head.data;
    case (w_head.funct3)
      F3_SB:   begin w_sz = 4'h1; w_mdata = {24'h0, w_head.data[7:0]};  end
      F3_SH:   begin w_sz = 4'h3; w_mdata = {16'h0, w_head.data[15:0]}; end
      default: ;
    endcase
    w_be64 = {4'h0, w_sz} << w_head.addr[1:0];
    w_d64  = {32'h0, w_mdata} << {w_head.addr[1:0], 3'b000};
  end

  // FIFO storage; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (w_push) fifo_q[wr_ptr_q] <= {bus_if.st_funct3, bus_if.st_addr, bus_if.st_data};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + C_PTR_ONE;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + C_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + C_CNT_ONE;
        2'b01:   count_q <= count_q - C_CNT_ONE;
        default: ;
      endcase
    end
  end

  // Write FSM with registered bus outputs; beat1 is precomputed at pop time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      b1_addr_q  <= '0;
      b1_wdata_q <= '0;
      b1_be_q    <= '0;
      split_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_pop) begin
            state_q    <= BEAT0;
            req_q      <= 1'b1;
            addr_q     <= {w_head.addr[31:2], 2'b00};
            wdata_q    <= w_d64[31:0];
            be_q       <= w_be64[3:0];
            b1_addr_q  <= {w_head.addr[31:2], 2'b00} + 32'd4;
            b1_wdata_q <= w_d64[63:32];
            b1_be_q    <= w_be64[7:4];
            split_q    <= w_split;
          end
        end
        BEAT0: begin
          if (bus_if.mem_gnt) begin
            if (split_q) begin
              state_q <= BEAT1;
              addr_q  <= b1_addr_q;
              wdata_q <= b1_wdata_q;
              be_q    <= b1_be_q;
            end else begin
              state_q <= IDLE;
              req_q   <= 1'b0;
              addr_q  <= '0;
              wdata_q <= '0;
              be_q    <= '0;
            end
          end
        end
        BEAT1: begin
          if (bus_if.mem_gnt) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          addr_q  <= '0;
          wdata_q <= '0;
          be_q    <= '0;
        end
      endcase
    end
  end

  // One-cycle status pulses for requests that were accepted but dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_q    <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      illegal_q <= w_accept & w_bad_f3;
`ifdef MISALIGN_SPLIT_EN
      misaligned_q <= 1'b0;
`else
      misaligned_q <= w_accept & w_misaligned;
`endif
    end
  end

  assign bus_if.st_ready      = ~w_full;
  assign bus_if.mem_req       = req_q;
  assign bus_if.mem_addr      = addr_q;
  assign bus_if.mem_wdata     = wdata_q;
  assign bus_if.mem_be        = be_q;
  assign bus_if.st_illegal    = illegal_q;
  assign bus_if.st_misaligned = misaligned_q;
  assign bus_if.busy          = (count_q != '0) || (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_store_write_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_store_write_ctrl
// Description : Scoreboard bench for store_write_ctrl. A byte-level memory
//               model predicts the write beats of each accepted store; a
//               monitor checks every granted beat, hold stability and idle
//               zeroing. Directed cases cover latency, stalls, full FIFO,
//               misaligned/illegal drops and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_write_ctrl;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  store_write_ctrl_if bus();

  store_write_ctrl #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus)
  );

  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  beat_t exp_q[$];
  int    exp_ill = 0, exp_mis = 0, seen_ill = 0, seen_mis = 0;
  int    gnt_mode = 1;   // 0: never grant, 1: always grant, 2: random grant

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference model: place each store byte at its own byte address, then
  // group the bytes by the word they fall into (first word, then next word).
  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int          n, lane;
    logic [31:0] ba, w0;
    beat_t       b0, b1;
    logic        two;
    if (f3 > 3'd2) begin
      exp_ill++;
      return;
    end
    n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
`ifndef MISALIGN_SPLIT_EN
    if ((a % 32'(n)) != 32'd0) begin
      exp_mis++;
      return;
    end
`endif
    w0  = {a[31:2], 2'b00};
    b0  = {w0, 32'h0, 4'h0};
    b1  = {w0 + 32'd4, 32'h0, 4'h0};
    two = 1'b0;
    for (int i = 0; i < n; i++) begin
      ba   = a + 32'(i);
      lane = int'(ba[1:0]);
      if ({ba[31:2], 2'b00} == w0) begin
        b0.be[lane] = 1'b1;
        b0.wdata[8*lane +: 8] = d[8*i +: 8];
      end else begin
        b1.be[lane] = 1'b1;
        b1.wdata[8*lane +: 8] = d[8*i +: 8];
        two = 1'b1;
      end
    end
    exp_q.push_back(b0);
    if (two) exp_q.push_back(b1);
  endtask

  // Present one request; call just after a rising edge, returns 1ns after the accepting edge.
  task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int wc;
    wc = 0;
    bus.st_valid = 1'b1;
    bus.st_funct3 = f3;
    bus.st_addr = a;
    bus.st_data = d;
    @(negedge clk);
    while (!bus.st_ready && wc < 500) begin
      @(negedge clk);
      wc++;
    end
    if (!bus.st_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: st_ready=0 after %0d cycles, required 1", wc);
      bus.st_valid = 1'b0;
      return;
    end
    model_store(f3, a, d);
    @(posedge clk);
    #1;
    bus.st_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain"}, {exp_q.size(), 8'(bus.busy)}, 72'h0);
    @(posedge clk);
    #1;
  endtask

  // Grant driver: changes 1ns after each rising edge.
  initial begin
    bus.mem_gnt = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (gnt_mode)
        0:       bus.mem_gnt = 1'b0;
        1:       bus.mem_gnt = 1'b1;
        default: bus.mem_gnt = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Monitor: checks every granted beat against the scoreboard and the handshake rules.
  initial begin : monitor
    logic  prev_stall;
    beat_t prev, cur, e;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        cur = {bus.mem_addr, bus.mem_wdata, bus.mem_be};
        if (bus.st_illegal) seen_ill++;
        if (bus.st_misaligned) seen_mis++;
        if (prev_stall) begin
          chk("hold_req", bus.mem_req, 1);
          chk("hold_beat", cur, prev);
        end
        if (!bus.mem_req) begin
          chk("idle_zero", cur, 0);
        end else if (bus.mem_gnt) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %0h, expected no beat", cur);
          end else begin
            e = exp_q.pop_front();
            chk("beat_addr", bus.mem_addr, e.addr);
            chk("beat_wdata", bus.mem_wdata, e.wdata);
            chk("beat_be", bus.mem_be, e.be);
          end
        end
        prev_stall = bus.mem_req && !bus.mem_gnt;
        prev = cur;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int          n, hi, idle, sel;
    logic [2:0]  f3;
    logic [31:0] a;

    bus.st_valid = 1'b0;
    bus.st_funct3 = 3'b000;
    bus.st_addr = '0;
    bus.st_data = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.st_ready, 1);
    chk("rst_req", bus.mem_req, 0);
    chk("rst_beat", {bus.mem_addr, bus.mem_wdata, bus.mem_be}, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_pulses", {bus.st_illegal, bus.st_misaligned}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // SB at byte 3, immediate grant: two-cycle latency then one idle bubble.
    gnt_mode = 1;
    send(3'b000, 32'h0000_1003, 32'hAABB_CCDD);
    @(negedge clk);
    chk("t1_lat_early", bus.mem_req, 0);
    @(negedge clk);
    chk("t1_lat_req", bus.mem_req, 1);
    chk("t1_addr", bus.mem_addr, 32'h0000_1000);
    chk("t1_wdata", bus.mem_wdata, 32'hDD00_0000);
    chk("t1_be", bus.mem_be, 4'b1000);
    @(negedge clk);
    chk("t1_bubble", bus.mem_req, 0);
    drain("t1");

    // SH with the grant held off for three cycles.
    gnt_mode = 0;
    send(3'b001, 32'h0000_2002, 32'hAABB_CCDD);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.mem_req && n < 20);
    chk("t2_req_seen", bus.mem_req, 1);
    chk("t2_wdata", bus.mem_wdata, 32'hCCDD_0000);
    chk("t2_be", bus.mem_be, 4'b1100);
    hi = 1;
    for (int k = 0; k < 10; k++) begin
      if (hi == 3) gnt_mode = 1;
      @(negedge clk);
      if (bus.mem_req) hi++;
      else break;
    end
    chk("t2_req_cycles", hi, 4);
    drain("t2");

    // Full FIFO: with no grants, DEPTH entries queue behind the one in flight.
    gnt_mode = 0;
    for (int i = 0; i <= DEPTH; i++) send(3'b010, 32'h0000_4000 + 32'(4*i), $urandom);
    @(negedge clk);
    chk("t3_full_ready", bus.st_ready, 0);
    chk("t3_full_busy", bus.busy, 1);
    fork
      send(3'b010, 32'h0000_5000, 32'h0BAD_F00D);
      begin
        repeat (3) @(negedge clk);
        chk("t3_still_full", bus.st_ready, 0);
        gnt_mode = 1;
      end
    join
    drain("t3");

    // Misaligned SW.
    send(3'b010, 32'h0000_1001, 32'hAABB_CCDD);
`ifdef MISALIGN_SPLIT_EN
    @(negedge clk);
    @(negedge clk);
    chk("t4_b0", {bus.mem_addr, bus.mem_wdata, bus.mem_be}, {32'h0000_1000, 32'hBBCC_DD00, 4'b1110});
    @(negedge clk);
    chk("t4_b1", {bus.mem_addr, bus.mem_wdata, bus.mem_be}, {32'h0000_1004, 32'h0000_00AA, 4'b0001});
`else
    @(negedge clk);
    chk("t4_mis_pulse", bus.st_misaligned, 1);
    chk("t4_mis_busy", bus.busy, 0);
    @(negedge clk);
    chk("t4_mis_end", bus.st_misaligned, 0);
    chk("t4_mis_noreq", bus.mem_req, 0);
`endif
    drain("t4");

    // Illegal funct3.
    send(3'b011, 32'h0000_1000, 32'h1234_5678);
    @(negedge clk);
    chk("t5_ill_pulse", bus.st_illegal, 1);
    chk("t5_ill_busy", bus.busy, 0);
    chk("t5_ill_noreq", bus.mem_req, 0);
    @(negedge clk);
    chk("t5_ill_end", bus.st_illegal, 0);
    chk("t5_ill_busy2", bus.busy, 0);
    drain("t5");

    // Randomized traffic with random grants, including the top-of-memory wrap.
    gnt_mode = 2;
    for (int i = 0; i < 300; i++) begin
      idle = $urandom_range(0, 3);
      if (idle != 0) begin
        repeat (idle) @(posedge clk);
        #1;
      end
      f3  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      sel = $urandom_range(0, 3);
      a   = (sel == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3))) : $urandom;
      send(f3, a, $urandom);
    end
    drain("rand");
    chk("illegal_count", seen_ill, exp_ill);
    chk("misaligned_count", seen_mis, exp_mis);

    // Asynchronous reset while a beat is stalled, with another store queued.
    gnt_mode = 0;
`ifdef MISALIGN_SPLIT_EN
    send(3'b010, 32'h0000_1001, 32'h1122_3344);
`else
    send(3'b010, 32'h0000_1000, 32'h1122_3344);
`endif
    send(3'b010, 32'h0000_3000, 32'h5566_7788);
    n = 0;
    while (!bus.mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_req_seen", bus.mem_req, 1);
`ifdef MISALIGN_SPLIT_EN
    gnt_mode = 1;
    @(negedge clk);
    gnt_mode = 0;
    @(negedge clk);
    chk("t6_in_beat1", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h0000_1004});
`endif
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("t6_req_async", bus.mem_req, 0);
    chk("t6_busy_async", bus.busy, 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    gnt_mode = 1;
    @(negedge clk);
    chk("t6_ready", bus.st_ready, 1);
    chk("t6_busy", bus.busy, 0);
    repeat (10) @(negedge clk);
    chk("t6_flushed", {bus.busy, bus.mem_req}, 0);
    chk("end_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
